// File: rtl/eth_mii_pkg.sv
// eth_mii_pkg: shared MII framing types and constants
package eth_mii_pkg;
  typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, ERR, IFG} tx_state_e;
  localparam logic [3:0] NIB_PRE = 4'h5;
  localparam logic [3:0] NIB_SFD = 4'hD;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
  localparam int BYTE_CNT_W = 11;
endpackage

// File: rtl/eth_crc32_byte.sv
// eth_crc32_byte: combinational reflected CRC-32 update for one byte
module eth_crc32_byte
  import eth_mii_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);
  logic [31:0] c;
  always_comb begin
    c = crc_i ^ {24'h0, data_i};
    for (int i = 0; i < 8; i++) c = c[0] ? (c >> 1) ^ CRC32_POLY_REFL : c >> 1;
    crc_o = c;
  end
endmodule

// File: rtl/mii_frame_tx.sv
// mii_frame_tx: byte stream to MII frame (preamble, SFD, data, pad, FCS, IFG)
module mii_frame_tx
  import eth_mii_pkg::*;
#(
  parameter int PRE_NIBBLES = 15,
  parameter int MIN_FRAME   = 60,
  parameter int IFG_NIBBLES = 24,
  parameter bit APPEND_FCS  = 1'b1
) (
  input  logic       clk_mii,
  input  logic       reset,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic       mii_tx_en,
  output logic [3:0] mii_txd,
  output logic       mii_tx_er,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);
  tx_state_e state_q, state_d;
  logic phase_q, phase_d, last_q, last_d;
  logic [7:0] cnt_q, cnt_d, byte_q, byte_d;
  logic [BYTE_CNT_W-1:0] bcnt_q, bcnt_d, bcnt_base, bcnt_inc;
  logic [31:0] crc_q, crc_d, crc_nx, fcs;
  logic tx_en_q, tx_er_q, busy_q, done_q, urun_q, tx_en_d, done_d;
  logic [3:0] txd_q, txd_d;
  assign s_ready = (state_q == SFD) || (state_q == DATA && phase_q && !last_q);
  assign bcnt_base = (state_q == SFD) ? '0 : bcnt_q;
  assign bcnt_inc = (&bcnt_base) ? bcnt_base : bcnt_base + 1'b1;
  assign fcs = ~crc_q;
  // Pad bytes are zero; every other load takes the input byte
  eth_crc32_byte u_crc (.crc_i(crc_q), .data_i(s_ready ? s_data : 8'h00), .crc_o(crc_nx));
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d = cnt_q + 8'd1;
    bcnt_d = bcnt_q;
    byte_d = byte_q;
    last_d = last_q;
    crc_d = crc_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (s_valid) begin
          state_d = PRE;
          crc_d = CRC32_INIT;
        end
      end
      PRE: if (cnt_q == 8'(PRE_NIBBLES - 1)) state_d = SFD;
      SFD, DATA, PAD:
        if (s_ready) begin
          state_d = s_valid ? DATA : ERR;
          phase_d = 1'b0;
          if (s_valid) begin
            byte_d = s_data;
            last_d = s_last;
            bcnt_d = bcnt_inc;
            crc_d = crc_nx;
          end
        end else if (!phase_q) phase_d = 1'b1;
        else if (int'(bcnt_q) < MIN_FRAME) begin
          state_d = PAD;
          phase_d = 1'b0;
          byte_d = 8'h00;
          bcnt_d = bcnt_inc;
          crc_d = crc_nx;
        end else begin
          state_d = APPEND_FCS ? FCS : IFG;
          cnt_d = '0;
        end
      FCS: if (cnt_q == 8'd7) begin
        state_d = IFG;
        cnt_d = '0;
      end
      ERR: begin
        state_d = IFG;
        cnt_d = '0;
      end
      IFG: if (cnt_q == 8'(IFG_NIBBLES - 1)) begin
        state_d = s_valid ? PRE : IDLE;
        cnt_d = '0;
        crc_d = CRC32_INIT;
      end
      default: state_d = IDLE;
    endcase
  end
  assign tx_en_d = !(state_d inside {IDLE, IFG});
  assign txd_d = state_d == PRE  ? NIB_PRE :
                 state_d == SFD  ? NIB_SFD :
                 state_d == DATA ? (phase_d ? byte_d[7:4] : byte_d[3:0]) :
                 state_d == FCS  ? fcs[{cnt_d[2:0], 2'b00} +: 4] : 4'h0;
  assign done_d = APPEND_FCS ? (state_d == FCS && cnt_d == 8'd7) :
                  (phase_d && !phase_q && (state_d == PAD || (state_d == DATA && last_q))
                   && int'(bcnt_q) >= MIN_FRAME);
  always_ff @(posedge clk_mii) begin
    if (reset) begin
      state_q <= IDLE;
      phase_q <= 1'b0;
      cnt_q <= '0;
      bcnt_q <= '0;
      byte_q <= '0;
      last_q <= 1'b0;
      crc_q <= CRC32_INIT;
      tx_en_q <= 1'b0;
      txd_q <= '0;
      tx_er_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      urun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q <= cnt_d;
      bcnt_q <= bcnt_d;
      byte_q <= byte_d;
      last_q <= last_d;
      crc_q <= crc_d;
      tx_en_q <= tx_en_d;
      txd_q <= txd_d;
      tx_er_q <= state_d == ERR;
      busy_q <= state_d != IDLE;
      done_q <= done_d;
      urun_q <= state_d == ERR;
    end
  end
  assign mii_tx_en = tx_en_q;
  assign mii_txd = txd_q;
  assign mii_tx_er = tx_er_q;
  assign busy = busy_q;
  assign frame_done = done_q;
  assign underrun = urun_q;
endmodule

// File: tb/tb_mii_frame_tx.sv
// tb_mii_frame_tx: random frames checked against a byte-level frame model
module tb_mii_frame_tx;
  logic clk_mii = 1'b0;
  logic reset = 1'b1;
  always #5 clk_mii = ~clk_mii;
  logic [7:0] s_data[2];
  logic [3:0] txd[2];
  logic s_valid[2], s_last[2], s_ready[2], tx_en[2], tx_er[2], busy[2], done[2], urun[2];
  int n_vec = 0, n_err = 0;
  mii_frame_tx u_dut (
    .clk_mii(clk_mii), .reset(reset), .s_data(s_data[0]), .s_valid(s_valid[0]), .s_last(s_last[0]),
    .s_ready(s_ready[0]), .mii_tx_en(tx_en[0]), .mii_txd(txd[0]), .mii_tx_er(tx_er[0]),
    .busy(busy[0]), .frame_done(done[0]), .underrun(urun[0]));
  mii_frame_tx #(.MIN_FRAME(0)) u_dut_nopad (
    .clk_mii(clk_mii), .reset(reset), .s_data(s_data[1]), .s_valid(s_valid[1]), .s_last(s_last[1]),
    .s_ready(s_ready[1]), .mii_tx_en(tx_en[1]), .mii_txd(txd[1]), .mii_tx_er(tx_er[1]),
    .busy(busy[1]), .frame_done(done[1]), .underrun(urun[1]));
  logic [4:0] cap[2][$];
  int gaps[2][$];
  int frames[2], dones[2], uruns[2], idle[2];
  bit prev_en[2];
  logic [4:0] exp_q[$];
  always @(negedge clk_mii) begin
    for (int d = 0; d < 2; d++) begin
      if (tx_en[d]) begin
        cap[d].push_back({tx_er[d], txd[d]});
        if (!prev_en[d]) gaps[d].push_back(idle[d]);
        idle[d] = 0;
      end else idle[d]++;
      if (prev_en[d] && !tx_en[d]) frames[d]++;
      dones[d] += int'(done[d]);
      uruns[d] += int'(urun[d]);
      prev_en[d] = tx_en[d];
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r = c;
    for (int k = 0; k < 8; k++) r = ((r ^ {31'h0, b[k]}) & 32'h1) != 0 ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction
  function automatic void add_exp(input int minf, input logic [7:0] q[$]);
    logic [7:0] b[$];
    logic [31:0] c = 32'hFFFFFFFF;
    b = q;
    while (b.size() < minf) b.push_back(8'h00);
    for (int i = 0; i < 15; i++) exp_q.push_back(5'h05);
    exp_q.push_back(5'h0D);
    foreach (b[i]) begin
      exp_q.push_back({1'b0, b[i][3:0]});
      exp_q.push_back({1'b0, b[i][7:4]});
      c = crc_upd(c, b[i]);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back({1'b0, c[8*k +: 4]});
      exp_q.push_back({1'b0, c[8*k+4 +: 4]});
    end
  endfunction
  function automatic logic [31:0] residue(input int d);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 16; i + 1 < cap[d].size(); i += 2) c = crc_upd(c, {cap[d][i+1][3:0], cap[d][i][3:0]});
    return c;
  endfunction
  task automatic rand_q(output logic [7:0] q[$], input int n);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
  endtask
  task automatic send(input int d, input logic [7:0] q[$], input bit mark_last);
    int g;
    foreach (q[i]) begin
      s_data[d] = q[i];
      s_valid[d] = 1'b1;
      s_last[d] = mark_last && i == q.size() - 1;
      g = 0;
      while (!s_ready[d] && g < 500) begin
        @(negedge clk_mii);
        g++;
      end
      chk($sformatf("rdy_wait d%0d b%0d", d, i), 32'(g < 500), 32'd1);
      @(negedge clk_mii);
    end
    s_last[d] = 1'b0;
  endtask
  task automatic wait_frames(input int d, input int n);
    int g = 0;
    while (frames[d] < n && g < 5000) begin
      @(negedge clk_mii);
      g++;
    end
    chk($sformatf("frame_end d%0d", d), 32'(frames[d] >= n), 32'd1);
  endtask
  task automatic check_cap(input int d, input string tag);
    chk({tag, "_len"}, cap[d].size(), exp_q.size());
    foreach (exp_q[i]) chk($sformatf("%s_nib%0d", tag, i), i < cap[d].size() ? 32'(cap[d][i]) : 32'hFFFF, 32'(exp_q[i]));
  endtask
  task automatic clear(input int d);
    cap[d].delete();
    gaps[d].delete();
    exp_q.delete();
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    logic [7:0] q[$], qa[$], qb[$], s9[$];
    int f0, d0, u0;
    logic [31:0] chkv = 32'hCBF43926;
    for (int d = 0; d < 2; d++) begin
      s_valid[d] = 1'b0;
      s_data[d] = 8'h00;
      s_last[d] = 1'b0;
    end
    repeat (3) @(negedge clk_mii);
    chk("rst_tx_en", 32'(tx_en[0]), 0);
    chk("rst_txd", 32'(txd[0]), 0);
    chk("rst_tx_er", 32'(tx_er[0]), 0);
    chk("rst_ready", 32'(s_ready[0]), 0);
    chk("rst_busy", 32'(busy[0]), 0);
    chk("rst_done", 32'(done[0]), 0);
    chk("rst_urun", 32'(urun[0]), 0);
    reset = 1'b0;
    @(negedge clk_mii);
    // 64-byte frame with valid held, plus IDLE->PRE latency
    rand_q(q, 64);
    clear(0);
    add_exp(60, q);
    f0 = frames[0]; d0 = dones[0]; u0 = uruns[0];
    s_data[0] = q[0];
    s_valid[0] = 1'b1;
    @(negedge clk_mii);
    chk("lat_tx_en", 32'(tx_en[0]), 1);
    chk("lat_txd", 32'(txd[0]), 5);
    chk("lat_ready", 32'(s_ready[0]), 0);
    chk("lat_busy", 32'(busy[0]), 1);
    send(0, q, 1'b1);
    s_valid[0] = 1'b0;
    wait_frames(0, f0 + 1);
    check_cap(0, "t1");
    chk("t1_residue", residue(0), 32'hDEBB20E3);
    chk("t1_done", dones[0] - d0, 1);
    chk("t1_urun", uruns[0] - u0, 0);
    repeat (30) @(negedge clk_mii);
    chk("t1_idle_busy", 32'(busy[0]), 0);
    // check string on the unpadded instance
    for (int i = 0; i < 9; i++) s9.push_back(8'h31 + 8'(i));
    clear(1);
    add_exp(0, s9);
    f0 = frames[1]; d0 = dones[1];
    send(1, s9, 1'b1);
    s_valid[1] = 1'b0;
    wait_frames(1, f0 + 1);
    check_cap(1, "t2");
    for (int k = 0; k < 4; k++)
      chk($sformatf("t2_fcs%0d", k), {cap[1][35+2*k][3:0], cap[1][34+2*k][3:0]}, chkv[8*k +: 8]);
    chk("t2_first_fcs_nib", 32'(cap[1][34]), 6);
    chk("t2_done", dones[1] - d0, 1);
    repeat (30) @(negedge clk_mii);
    // short frame gets zero padding
    rand_q(q, 14);
    clear(0);
    add_exp(60, q);
    f0 = frames[0];
    send(0, q, 1'b1);
    s_valid[0] = 1'b0;
    wait_frames(0, f0 + 1);
    chk("t3_len", cap[0].size(), 16 + 120 + 8);
    check_cap(0, "t3");
    chk("t3_residue", residue(0), 32'hDEBB20E3);
    repeat (30) @(negedge clk_mii);
    // underrun after byte 20
    rand_q(q, 20);
    clear(0);
    f0 = frames[0]; d0 = dones[0]; u0 = uruns[0];
    send(0, q, 1'b0);
    s_valid[0] = 1'b0;
    wait_frames(0, f0 + 1);
    chk("t4_len", cap[0].size(), 57);
    chk("t4_last_data", 32'(cap[0][55]), {27'h0, 1'b0, q[19][7:4]});
    chk("t4_err_nib", 32'(cap[0][56]), 32'h10);
    chk("t4_urun", uruns[0] - u0, 1);
    chk("t4_done", dones[0] - d0, 0);
    // back-to-back frames right after the aborted one
    rand_q(qa, 64);
    rand_q(qb, 20);
    clear(0);
    add_exp(60, qa);
    add_exp(60, qb);
    f0 = frames[0]; d0 = dones[0];
    send(0, qa, 1'b1);
    send(0, qb, 1'b1);
    s_valid[0] = 1'b0;
    wait_frames(0, f0 + 2);
    check_cap(0, "t5");
    chk("t5_gap_cnt", gaps[0].size(), 2);
    chk("t5_gap_after_err", gaps[0].size() > 0 ? gaps[0][0] : -1, 24);
    chk("t5_gap_b2b", gaps[0].size() > 1 ? gaps[0][1] : -1, 24);
    chk("t5_done", dones[0] - d0, 2);
    repeat (30) @(negedge clk_mii);
    // reset in the middle of byte 30
    rand_q(q, 30);
    clear(0);
    send(0, q, 1'b0);
    d0 = dones[0]; u0 = uruns[0];
    reset = 1'b1;
    @(negedge clk_mii);
    chk("t6_tx_en", 32'(tx_en[0]), 0);
    chk("t6_busy", 32'(busy[0]), 0);
    chk("t6_ready", 32'(s_ready[0]), 0);
    reset = 1'b0;
    s_valid[0] = 1'b0;
    repeat (5) @(negedge clk_mii);
    chk("t6_no_done", dones[0] - d0, 0);
    chk("t6_no_urun", uruns[0] - u0, 0);
    rand_q(q, 70);
    clear(0);
    add_exp(60, q);
    f0 = frames[0];
    send(0, q, 1'b1);
    s_valid[0] = 1'b0;
    wait_frames(0, f0 + 1);
    check_cap(0, "t6");
    chk("t6_residue", residue(0), 32'hDEBB20E3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
